wb_mem_arbiter: RTL and testbench

- Two-master, one-slave Wishbone arbiter that shares the user-project memory port between the CPU-side Wishbone path (M0) and the DMA engine's master port (M1).
- The DMA engine feeds the FIR and matrix-multiply AXI-stream engines.
- Provides round-robin arbitration, grant hold for the duration of a master's cycle, a burst cap so the DMA cannot starve the CPU, and a no-ack timeout that returns an error to the stalled master.

---
 rtl/wb_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter.sv
// Two-master / one-slave Wishbone arbiter for the user-project memory port.
// Round-robin with grant hold, DMA burst cap and a no-ack timeout that errors the stalled master.
module wb_mem_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    localparam int unsigned BeatW = $clog2(MAX_BURST + 1);
    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
    localparam logic [BeatW-1:0] BeatMax  = BeatW'(MAX_BURST);
    localparam logic [WaitW-1:0] WaitMax  = WaitW'(TIMEOUT);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, GNT0, GNT1, ERR0, ERR1} state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;   // 1'b0 = M0 held the last grant, 1'b1 = M1
    logic [BeatW-1:0] beat_q, beat_d;
    logic [WaitW-1:0] wait_q, wait_d;

    logic             req0, req1;
    logic             sel1, cur_cyc, cur_stb, oth_req, beat_ack;
    logic [BeatW-1:0] beat_inc;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            beat_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state, counters and the combinational bus mux.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m0_dat_o  = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        m1_dat_o  = '0;
        grant_o   = 2'b00;
        timeout_o = 1'b0;

        sel1     = (state_q == GNT1);
        cur_cyc  = sel1 ? m1_cyc_i : m0_cyc_i;
        cur_stb  = sel1 ? m1_stb_i : m0_stb_i;
        oth_req  = sel1 ? req0 : req1;
        beat_ack = s_ack_i & cur_stb;
        beat_inc = (beat_q == BeatMax) ? beat_q : beat_q + 1'b1;

        case (state_q)
            IDLE: begin
                // Ties go to whichever master did not hold the previous grant.
                if (req0 && (!req1 || last_q)) begin
                    state_d = GNT0;
                    beat_d  = '0;
                    wait_d  = '0;
                end else if (req1) begin
                    state_d = GNT1;
                    beat_d  = '0;
                    wait_d  = '0;
                end
            end
            GNT0, GNT1: begin
                if (sel1) begin
                    s_cyc_o  = m1_cyc_i;
                    s_stb_o  = m1_stb_i;
                    s_we_o   = m1_we_i;
                    s_sel_o  = m1_sel_i;
                    s_adr_o  = m1_adr_i;
                    s_dat_o  = m1_dat_i;
                    m1_ack_o = s_ack_i & m1_stb_i;
                    m1_dat_o = s_dat_i;
                    grant_o  = 2'b10;
                end else begin
                    s_cyc_o  = m0_cyc_i;
                    s_stb_o  = m0_stb_i;
                    s_we_o   = m0_we_i;
                    s_sel_o  = m0_sel_i;
                    s_adr_o  = m0_adr_i;
                    s_dat_o  = m0_dat_i;
                    m0_ack_o = s_ack_i & m0_stb_i;
                    m0_dat_o = s_dat_i;
                    grant_o  = 2'b01;
                end

                if (!cur_cyc) begin
                    state_d = IDLE;
                    last_d  = sel1;
                end else if (beat_ack) begin
                    // An ack on the threshold cycle beats the timeout.
                    wait_d = '0;
                    beat_d = beat_inc;
                    if ((beat_inc >= BeatMax) && oth_req) begin
                        state_d = IDLE;
                        last_d  = sel1;
                    end
                end else if (cur_stb) begin
                    wait_d = (wait_q == WaitMax) ? wait_q : wait_q + 1'b1;
                    if (wait_q == WaitLast) begin
                        state_d = sel1 ? ERR1 : ERR0;
                    end
                end
            end
            ERR0: begin
                m0_err_o  = 1'b1;
                timeout_o = 1'b1;
                state_d   = IDLE;
                last_d    = 1'b0;
            end
            ERR1: begin
                m1_err_o  = 1'b1;
                timeout_o = 1'b1;
                state_d   = IDLE;
                last_d    = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed scoreboard bench for wb_mem_arbiter: expected output events are queued by the
// stimulus and a negedge monitor compares every grant change / ack / err / timeout against them.
module tb_wb_mem_arbiter;

    logic        clk = 1'b0;
    logic        wb_rst_n;
    logic        m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
    logic [3:0]  m0_sel_i = '0;
    logic [31:0] m0_adr_i = '0, m0_dat_i = '0;
    logic        m0_ack_o, m0_err_o;
    logic [31:0] m0_dat_o;
    logic        m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
    logic [3:0]  m1_sel_i = '0;
    logic [31:0] m1_adr_i = '0, m1_dat_i = '0;
    logic        m1_ack_o, m1_err_o;
    logic [31:0] m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i = 1'b0;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    int t0       = 0;
    int slv_lat  = 1;
    int swc      = 0;
    logic abort  = 1'b0;

    typedef struct {
        int          rel;
        logic [1:0]  gnt;
        logic        scyc;
        logic        a0, e0, a1, e1, tmo;
        logic [31:0] d0, d1;
    } ev_t;

    ev_t exp_q[$];

    wb_mem_arbiter #(.MAX_BURST(4), .TIMEOUT(16)) dut (
        .wb_clk_i (clk),      .wb_rst_n (wb_rst_n),
        .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
        .m0_sel_i (m0_sel_i), .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i),
        .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o), .m0_dat_o (m0_dat_o),
        .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i),
        .m1_sel_i (m1_sel_i), .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i),
        .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o), .m1_dat_o (m1_dat_o),
        .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),  .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),  .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack_i),
        .grant_o  (grant_o),  .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Slave: acks slv_lat cycles after stb is first seen (0 = never), read data tagged by address.
    always @(posedge clk) begin
        if (!wb_rst_n || !(s_cyc_o && s_stb_o)) begin
            s_ack_i <= 1'b0;
            swc     <= 0;
        end else if (s_ack_i) begin
            s_ack_i <= 1'b0;
        end else if (slv_lat != 0 && swc == slv_lat - 1) begin
            s_ack_i <= 1'b1;
            swc     <= 0;
        end else begin
            swc <= swc + 1;
        end
    end

    assign s_dat_i = s_ack_i ? (32'h1234_5678 ^ s_adr_o) : 32'h0;

    function automatic string ev_str(input ev_t e);
        return $sformatf("rel=%0d gnt=%b scyc=%b ack0=%b err0=%b ack1=%b err1=%b tmo=%b d0=%h d1=%h",
                         e.rel, e.gnt, e.scyc, e.a0, e.e0, e.a1, e.e1, e.tmo, e.d0, e.d1);
    endfunction

    function automatic void push_ev(input int rel, input logic [1:0] g, input logic a0, input logic e0,
                                    input logic a1, input logic e1, input logic tmo,
                                    input logic [31:0] d0, input logic [31:0] d1);
        ev_t e;
        e.rel = rel; e.gnt = g; e.scyc = (g != 2'b00);
        e.a0 = a0; e.e0 = e0; e.a1 = a1; e.e1 = e1; e.tmo = tmo;
        e.d0 = d0; e.d1 = d1;
        exp_q.push_back(e);
    endfunction

    function automatic void ev_gnt(input int rel, input logic [1:0] g);
        push_ev(rel, g, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endfunction

    function automatic void ev_ack(input int rel, input int m, input logic [31:0] d);
        if (m == 0) push_ev(rel, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, d, 32'h0);
        else        push_ev(rel, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, d);
    endfunction

    function automatic void ev_err(input int rel, input int m);
        if (m == 0) push_ev(rel, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        else        push_ev(rel, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    endfunction

    task automatic drive(input int m, input logic c, input logic we, input logic [31:0] adr);
        if (m == 0) begin
            m0_cyc_i = c; m0_stb_i = c; m0_we_i = we; m0_sel_i = {4{c}};
            m0_adr_i = adr; m0_dat_i = ~adr;
        end else begin
            m1_cyc_i = c; m1_stb_i = c; m1_we_i = we; m1_sel_i = {4{c}};
            m1_adr_i = adr; m1_dat_i = ~adr;
        end
    endtask

    // Master BFM: holds cyc/stb for 'beats' acked beats (or until err/abort), address +4 per beat.
    task automatic mtxn(input int m, input int beats, input logic we, input logic [31:0] adr0);
        int n = 0;
        int guard = 0;
        logic [31:0] adr = adr0;
        logic got_ack, got_err;
        drive(m, 1'b1, we, adr);
        while (n < beats && guard < 400 && !abort) begin
            @(negedge clk);
            got_ack = (m == 0) ? m0_ack_o : m1_ack_o;
            got_err = (m == 0) ? m0_err_o : m1_err_o;
            @(posedge clk); #1;
            guard++;
            if (got_err) n = beats;
            else if (got_ack) begin n++; adr += 32'd4; end
            if (n < beats) drive(m, 1'b1, we, adr);
        end
        drive(m, 1'b0, 1'b0, 32'h0);
        if (guard >= 400) begin
            checks++;
            failures++;
            $display("FAIL master%0d_wait: got %0d of %0d beats before cycle budget", m, n, beats);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        wb_rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        wb_rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle_wait();
        repeat (4) begin @(posedge clk); #1; end
    endtask

    // Monitor: one scoreboard comparison per observable output event.
    logic [1:0] prev_gnt = 2'b00;
    ev_t act_ev, exp_ev;
    initial begin
        forever begin
            @(negedge clk);
            if (grant_o != prev_gnt || m0_ack_o || m0_err_o || m1_ack_o || m1_err_o || timeout_o) begin
                act_ev.rel = cyc_n - t0; act_ev.gnt = grant_o; act_ev.scyc = s_cyc_o;
                act_ev.a0 = m0_ack_o; act_ev.e0 = m0_err_o; act_ev.a1 = m1_ack_o; act_ev.e1 = m1_err_o;
                act_ev.tmo = timeout_o; act_ev.d0 = m0_dat_o; act_ev.d1 = m1_dat_o;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL event_unexpected: got %s, none required", ev_str(act_ev));
                end else begin
                    exp_ev = exp_q.pop_front();
                    if (ev_str(act_ev) != ev_str(exp_ev)) begin
                        failures++;
                        $display("FAIL event: got %s required %s", ev_str(act_ev), ev_str(exp_ev));
                    end
                end
            end
            prev_gnt = grant_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Requests held during reset must not leak through.
        wb_rst_n = 1'b0;
        drive(0, 1'b1, 1'b1, 32'hDEAD_BEEC);
        drive(1, 1'b1, 1'b1, 32'h0BAD_F00C);
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o} != 71'h0) begin
            failures++;
            $display("FAIL reset_slave_bus: got cyc=%b stb=%b adr=%h required all 0", s_cyc_o, s_stb_o, s_adr_o);
        end
        checks++;
        if ({m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o} != 68'h0) begin
            failures++;
            $display("FAIL reset_master_ret: got ack0=%b err0=%b ack1=%b err1=%b required 0",
                     m0_ack_o, m0_err_o, m1_ack_o, m1_err_o);
        end
        checks++;
        if ({grant_o, timeout_o} != 3'b000) begin
            failures++;
            $display("FAIL reset_grant: got grant=%b timeout=%b required 00/0", grant_o, timeout_o);
        end
        drive(0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        wb_rst_n = 1'b1;
        @(posedge clk); #1;

        // Single M0 read, slave latency 2.
        slv_lat = 2;
        t0 = cyc_n;
        ev_gnt(1, 2'b01); ev_ack(3, 0, 32'h1234_5678); ev_gnt(5, 2'b00);
        mtxn(0, 1, 1'b0, 32'h0);
        idle_wait();

        // Both request after reset, two single beats each: M0, M1, M0, M1.
        do_reset();
        slv_lat = 1;
        t0 = cyc_n;
        ev_gnt(1, 2'b01);  ev_ack(2, 0, 32'h1234_5778);  ev_gnt(4, 2'b00);
        ev_gnt(5, 2'b10);  ev_ack(6, 1, 32'h1234_5478);  ev_gnt(8, 2'b00);
        ev_gnt(9, 2'b01);  ev_ack(10, 0, 32'h1234_5778); ev_gnt(12, 2'b00);
        ev_gnt(13, 2'b10); ev_ack(14, 1, 32'h1234_5478); ev_gnt(16, 2'b00);
        fork
            begin mtxn(0, 1, 1'b0, 32'h100); @(posedge clk); #1; mtxn(0, 1, 1'b0, 32'h100); end
            begin mtxn(1, 1, 1'b0, 32'h200); @(posedge clk); #1; mtxn(1, 1, 1'b0, 32'h200); end
        join
        idle_wait();

        // Burst cap: M1 10 beats, M0 arrives at M1 beat 2.
        do_reset();
        slv_lat = 1;
        t0 = cyc_n;
        ev_gnt(1, 2'b10);
        ev_ack(2, 1, 32'h1234_5478); ev_ack(4, 1, 32'h1234_547C);
        ev_ack(6, 1, 32'h1234_5470); ev_ack(8, 1, 32'h1234_5474);
        ev_gnt(9, 2'b00); ev_gnt(10, 2'b01); ev_ack(11, 0, 32'h1234_5778);
        ev_gnt(13, 2'b00); ev_gnt(14, 2'b10);
        ev_ack(15, 1, 32'h1234_5468); ev_ack(17, 1, 32'h1234_546C);
        ev_ack(19, 1, 32'h1234_5460); ev_ack(21, 1, 32'h1234_5464);
        ev_ack(23, 1, 32'h1234_5458); ev_ack(25, 1, 32'h1234_545C);
        ev_gnt(27, 2'b00);
        fork
            mtxn(1, 10, 1'b0, 32'h200);
            begin repeat (4) @(posedge clk); #1; mtxn(0, 1, 1'b0, 32'h100); end
        join
        idle_wait();

        // Timeout: M1 write never acked.
        do_reset();
        slv_lat = 0;
        t0 = cyc_n;
        ev_gnt(1, 2'b10); ev_err(17, 1);
        mtxn(1, 1, 1'b1, 32'h300);
        idle_wait();

        // Ack lands on the timeout threshold cycle.
        do_reset();
        slv_lat = 15;
        t0 = cyc_n;
        ev_gnt(1, 2'b01); ev_ack(16, 0, 32'h1234_5678); ev_gnt(18, 2'b00);
        mtxn(0, 1, 1'b0, 32'h0);
        idle_wait();

        // Asynchronous reset mid-burst, then a fresh M0 request.
        do_reset();
        slv_lat = 1;
        t0 = cyc_n;
        ev_gnt(1, 2'b10); ev_ack(2, 1, 32'h1234_5478); ev_ack(4, 1, 32'h1234_547C);
        ev_gnt(5, 2'b00);
        ev_gnt(10, 2'b01); ev_ack(11, 0, 32'h1234_5678); ev_gnt(13, 2'b00);
        fork
            mtxn(1, 6, 1'b1, 32'h200);
            begin repeat (5) @(posedge clk); #2; wb_rst_n = 1'b0; abort = 1'b1; end
        join
        repeat (2) begin @(posedge clk); #1; end
        wb_rst_n = 1'b1;
        abort = 1'b0;
        @(posedge clk); #1;
        mtxn(0, 1, 1'b0, 32'h0);
        idle_wait();

        while (exp_q.size() != 0) begin
            exp_ev = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL event_missing: got nothing required %s", ev_str(exp_ev));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
